// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter (rf_wr_arb).
package rf_arb_pkg;

    localparam int unsigned DEF_STARVE_LIMIT = 4;
    // Queued data field width; the arbiter's DATA_WIDTH must not exceed it.
    localparam int unsigned MAX_DATA_WIDTH   = 32;
    localparam int unsigned REG_ADDR_WIDTH   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [MAX_DATA_WIDTH-1:0] data;
    } lu_entry_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// In-order queue of pending long-latency results, with occupancy count and
// full/empty flags; storage and read pointer are exposed for the hazard scoreboard.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  lu_entry_t              push_entry,
    input  logic                   pop,
    output lu_entry_t              head,
    output lu_entry_t [DEPTH-1:0]  entries,
    output logic      [PTR_W-1:0]  rd_ptr,
    output logic      [CNT_W-1:0]  count,
    output logic                   full,
    output logic                   empty
);

    lu_entry_t [DEPTH-1:0] mem;
    logic      [PTR_W-1:0] wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage has no reset; the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head    = mem[rd_ptr];
    assign entries = mem;

endmodule

// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter between the pipeline writeback and a queue of
// long-latency results. Optional starvation guard: define RF_ARB_STARVE_GUARD_EN.
module rf_wr_arb
    import rf_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_wew,
    input  logic [4:0]            rdw,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  lu_valid,
    input  logic [4:0]            lu_rd,
    input  logic [DATA_WIDTH-1:0] lu_data,
    output logic                  lu_ready,
    output logic                  rf_we,
    output logic [4:0]            rf_rd,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  pipe_stall,
    output logic [31:0]           lu_busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    lu_entry_t                  push_entry;
    lu_entry_t                  head;
    lu_entry_t [FIFO_DEPTH-1:0] entries;
    logic      [PTR_W-1:0]      rd_ptr;
    logic      [PTR_W-1:0]      slot_off;
    logic      [CNT_W-1:0]      count;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       drain;
    logic                       grant_valid;

    // Acceptance depends only on the registered count, never on this cycle's pop.
    assign lu_ready = !full;
    assign push     = lu_valid && lu_ready;

    always_comb begin
        push_entry.rd   = lu_rd;
        push_entry.data = MAX_DATA_WIDTH'(lu_data);
    end

    rf_arb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .entries    (entries),
        .rd_ptr     (rd_ptr),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int unsigned          WAIT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0]    WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0]    WAIT_TRIP = WAIT_W'(STARVE_LIMIT - 1);

    arb_state_e        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              blocked;
    logic              last_pop;

    assign drain    = (state == ST_DRAIN);
    assign blocked  = (state == ST_PEND) && reg_wew;
    assign last_pop = pop && !push && (count == CNT_W'(1));

    // pipe_stall is a registered image of "next state is DRAIN"; the async
    // reset clears it together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            pipe_stall <= 1'b0;
        end else begin
            pipe_stall <= 1'b0;

            if (pop) begin
                wait_cnt <= '0;
            end else if (blocked && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (push) begin
                        state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (last_pop) begin
                        state <= ST_IDLE;
                    end else if (blocked && wait_cnt == WAIT_TRIP) begin
                        state      <= ST_DRAIN;
                        pipe_stall <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state <= last_pop ? ST_IDLE : ST_PEND;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
`else
    assign drain      = 1'b0;
    assign pipe_stall = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no latch can form.
    always_comb begin
        pop         = 1'b0;
        grant_valid = 1'b0;
        rf_rd       = '0;
        rf_wdata    = '0;
        if (!drain && reg_wew) begin
            grant_valid = 1'b1;
            rf_rd       = rdw;
            rf_wdata    = result;
        end else if (!empty) begin
            pop         = 1'b1;
            grant_valid = 1'b1;
            rf_rd       = head.rd;
            rf_wdata    = DATA_WIDTH'(head.data);
        end
    end

    // x0 writes still pop their queue slot but never reach the register file.
    assign rf_we = grant_valid && (rf_rd != '0);

    // Scoreboard is rebuilt from live slots, so a bit stays set while any
    // queued entry still targets that register.
    always_comb begin
        lu_busy  = '0;
        slot_off = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_ptr;
            if (CNT_W'(slot_off) < count) begin
                lu_busy[entries[i].rd] = 1'b1;
            end
        end
        lu_busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed self-checking bench for rf_wr_arb; covers both RF_ARB_STARVE_GUARD_EN builds.
module tb_rf_wr_arb;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          reg_wew;
    logic [4:0]    rdw;
    logic [DW-1:0] result;
    logic          lu_valid;
    logic [4:0]    lu_rd;
    logic [DW-1:0] lu_data;
    logic          lu_ready;
    logic          rf_we;
    logic [4:0]    rf_rd;
    logic [DW-1:0] rf_wdata;
    logic          pipe_stall;
    logic [31:0]   lu_busy;

    int n_total = 0;
    int n_pass  = 0;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    rf_wr_arb #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_wew    (reg_wew),
        .rdw        (rdw),
        .result     (result),
        .lu_valid   (lu_valid),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .pipe_stall (pipe_stall),
        .lu_busy    (lu_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        reg_wew  = 1'b0;
        rdw      = '0;
        result   = '0;
        lu_valid = 1'b0;
        lu_rd    = '0;
        lu_data  = '0;
        #1;
        check("rst_lu_ready",   lu_ready,   1);
        check("rst_pipe_stall", pipe_stall, 0);
        check("rst_lu_busy",    lu_busy,    0);
        check("rst_rf_we",      rf_we,      0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Pipeline-only write reaches the register file in the same cycle.
        reg_wew = 1'b1; rdw = 5'd5; result = 32'hA5A5_A5A5;
        #1;
        check("pipe_we",    rf_we,    1);
        check("pipe_rd",    rf_rd,    5);
        check("pipe_wdata", rf_wdata, 32'hA5A5_A5A5);
        @(negedge clk);
        reg_wew = 1'b0;
        #1;
        check("pipe_off_we", rf_we, 0);

        // Single long-latency result with an idle pipeline.
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h12;
        #1;
        check("lu_ready_idle", lu_ready, 1);
        check("lu_no_same_cycle_we", rf_we, 0);
        @(negedge clk);
        lu_valid = 1'b0;
        #1;
        check("lu_we",    rf_we,    1);
        check("lu_rd",    rf_rd,    7);
        check("lu_wdata", rf_wdata, 32'h12);
        check("lu_busy7", lu_busy,  32'h0000_0080);
        @(negedge clk);
        #1;
        check("lu_busy7_clear", lu_busy, 0);
        check("lu_done_we",     rf_we,   0);

        // x0 entry pops silently; the entry behind it proves the slot was freed.
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h55;
        @(negedge clk);
        lu_rd = 5'd9; lu_data = 32'h99;
        #1;
        check("x0_we",    rf_we,    0);
        check("x0_busy",  lu_busy,  0);
        check("x0_ready", lu_ready, 1);
        @(negedge clk);
        lu_valid = 1'b0;
        #1;
        check("after_x0_rd",    rf_rd,    9);
        check("after_x0_we",    rf_we,    1);
        check("after_x0_wdata", rf_wdata, 32'h99);
        @(negedge clk);
        #1;
        check("after_x0_empty_we", rf_we,   0);
        check("after_x0_busy",     lu_busy, 0);

        // Contention: continuous pipeline writes with one queued result.
        reg_wew = 1'b1; rdw = 5'd3; result = 32'hCAFE;
        lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'hBEEF;
        #1;
        check("cont_m0_rd", rf_rd, 3);
        for (int i = 1; i <= (GUARD ? 4 : 6); i++) begin
            @(negedge clk);
            lu_valid = 1'b0;
            #1;
            check($sformatf("cont_stall_%0d", i), pipe_stall, 0);
            check($sformatf("cont_rd_%0d", i),    rf_rd,      3);
            check($sformatf("cont_busy_%0d", i),  lu_busy,    32'h0000_1000);
        end
        if (GUARD) begin
            @(negedge clk);
            #1;
            check("drain_stall", pipe_stall, 1);
            check("drain_we",    rf_we,      1);
            check("drain_rd",    rf_rd,      12);
            check("drain_wdata", rf_wdata,   32'hBEEF);
            @(negedge clk);
            #1;
            check("resume_stall", pipe_stall, 0);
            check("resume_rd",    rf_rd,      3);
            check("resume_busy",  lu_busy,    0);
            reg_wew = 1'b0;
        end else begin
            @(negedge clk);
            reg_wew = 1'b0;
            #1;
            check("noguard_head_rd",    rf_rd,    12);
            check("noguard_head_wdata", rf_wdata, 32'hBEEF);
            @(negedge clk);
            #1;
            check("noguard_empty_we", rf_we,   0);
            check("noguard_busy",     lu_busy, 0);
        end

        // Full queue: third result waits for a free slot; order preserved.
        @(negedge clk);
        reg_wew = 1'b1; rdw = 5'd2; result = 32'h2;
        lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 32'h1;
        @(negedge clk);
        lu_rd = 5'd21; lu_data = 32'h2;
        #1;
        check("full_ready_1", lu_ready, 1);
        @(negedge clk);
        lu_rd = 5'd22; lu_data = 32'h3;
        #1;
        check("full_ready_0", lu_ready, 0);
        check("full_busy",    lu_busy,  32'h0030_0000);
        check("full_pipe_rd", rf_rd,    2);
        @(negedge clk);
        reg_wew = 1'b0;
        #1;
        check("full_ready_still_0", lu_ready, 0);
        check("order_rd_20",        rf_rd,    20);
        check("order_wdata_1",      rf_wdata, 32'h1);
        @(negedge clk);
        #1;
        check("full_ready_after_pop", lu_ready, 1);
        check("order_rd_21",          rf_rd,    21);
        @(negedge clk);
        lu_valid = 1'b0;
        #1;
        check("order_rd_22",    rf_rd,    22);
        check("order_wdata_3",  rf_wdata, 32'h3);
        check("order_busy_22",  lu_busy,  32'h0040_0000);
        @(negedge clk);
        #1;
        check("order_done_we",   rf_we,   0);
        check("order_done_busy", lu_busy, 0);

        // Reset while draining with two queued entries.
        reg_wew = 1'b1; rdw = 5'd4; result = 32'h44;
        lu_valid = 1'b1; lu_rd = 5'd25; lu_data = 32'h250;
        @(negedge clk);
        lu_rd = 5'd26; lu_data = 32'h260;
        @(negedge clk);
        lu_valid = 1'b0;
        #1;
        check("rstd_ready_full", lu_ready, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rstd_pre_stall", pipe_stall, GUARD);
        check("rstd_pre_busy",  lu_busy,    32'h0600_0000);
        #2;
        rst = 1'b1;
        #1;
        check("rstd_stall", pipe_stall, 0);
        check("rstd_busy",  lu_busy,    0);
        check("rstd_ready", lu_ready,   1);
        check("rstd_pipe_rd", rf_rd,    4);
        @(negedge clk);
        rst = 1'b0;
        reg_wew = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("rstd_no_write_%0d", i), rf_we,    0);
            check($sformatf("rstd_ready_%0d", i),    lu_ready, 1);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rf_wr_arb.md
RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, register data width; FIFO_DEPTH, 2, pending long-latency result slots (power of 2, >=2); STARVE_LIMIT, 4, blocked cycles before forced drain.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 reg_wew  input  1  pipeline writeback enable.
REQ-005 rdw  input  5  pipeline destination register.
REQ-006 result  input  DATA_WIDTH  pipeline writeback data.
REQ-007 lu_valid  input  1  long-latency unit (mul/div/miss) result valid.
REQ-008 lu_rd  input  5  long-latency destination register.
REQ-009 lu_data  input  DATA_WIDTH  long-latency result data.
REQ-010 lu_ready  output  1  arbiter can accept a long-latency result.
REQ-011 rf_we  output  1  register-file write enable.
REQ-012 rf_rd  output  5  register-file write address.
REQ-013 rf_wdata  output  DATA_WIDTH  register-file write data.
REQ-014 pipe_stall  output  1  pipeline SHALL hold its writeback inputs this cycle.
REQ-015 lu_busy  output  32  bit i set while a queued entry targets register i (hazard scoreboard).

Function
REQ-016 Long-latency transfer SHALL occur on lu_valid && lu_ready; accepted entry pushed to in-order FIFO; lu_ready = FIFO not full (from registered count only).
REQ-017 Pipeline write SHALL reach rf_* combinationally in the same cycle (zero latency); queued entry earliest write is the cycle after acceptance.
REQ-018 FSM states: IDLE (FIFO empty), PEND (FIFO non-empty), DRAIN (forced grant to FIFO head).
REQ-019 IDLE->PEND on push; PEND->IDLE on pop leaving FIFO empty with no push; PEND->DRAIN when wait_cnt reaches STARVE_LIMIT; DRAIN->PEND after one pop if FIFO still non-empty, else ->IDLE.
REQ-020 Grant in IDLE/PEND: reg_wew=1 -> pipeline; else FIFO head if non-empty; else rf_we=0.
REQ-021 In DRAIN: pipe_stall=1, reg_wew ignored, FIFO head written and popped; pipe_stall=0 in all other states.
REQ-022 wait_cnt SHALL increment each PEND cycle the head is blocked by reg_wew, clear on any pop, saturate at STARVE_LIMIT.
REQ-023 Writes with destination 0 SHALL give rf_we=0; queued entries to x0 still consume a pop slot.
REQ-024 Simultaneous push and pop SHALL both take effect; count unchanged.
REQ-025 lu_busy bit set on push, cleared on pop of that entry only if no other queued entry targets same rd; x0 bit always 0.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-027 On rst: FIFO emptied (pending results discarded), state IDLE, wait_cnt 0, lu_busy 0, lu_ready 1, pipe_stall 0; rf_we follows REQ-020 with empty FIFO.
REQ-028 Reset asserted mid-DRAIN SHALL drop pipe_stall immediately (asynchronously).

Configuration
REQ-029 Macro RF_ARB_STARVE_GUARD_EN: defined -> DRAIN state and wait_cnt per REQ-019..022; undefined -> no DRAIN, no counter, pipeline always has priority, pipe_stall tied 0.

Structure
REQ-030 Package rf_arb_pkg SHALL hold the FSM state enum, default STARVE_LIMIT, and the queued-entry struct {rd, data}.
REQ-031 One sub-module rf_arb_fifo (synchronous FIFO with count, full, empty) SHALL hold the queue; arbitration and FSM in rf_wr_arb.

Verification
REQ-032 Pipeline only: reg_wew=1, rdw=5, result=0xA5A5A5A5 -> same cycle rf_we=1, rf_rd=5, rf_wdata=0xA5A5A5A5.
REQ-033 LU idle pipe: lu_valid, lu_rd=7, lu_data=0x12 -> next cycle rf_we=1, rf_rd=7; lu_busy[7] high exactly one cycle.
REQ-034 Contention: reg_wew=1 continuously, one LU push, guard on, STARVE_LIMIT=4 -> 4 pipeline writes, then pipe_stall=1 for one cycle with LU write, then pipeline resumes.
REQ-035 Full: two LU pushes while pipeline writes (guard off) -> lu_ready=0; third lu_valid held until pop; order preserved.
REQ-036 x0: lu_rd=0 pushed -> rf_we never 1 for it, FIFO count returns to 0, lu_busy stays 0.
REQ-037 rst asserted during DRAIN with FIFO holding 2 entries -> pipe_stall, lu_busy, count 0 immediately; lu_ready=1; no queued write after release.
